// File: rtl/systolic_result_collector.sv
// systolic_result_collector: de-skews N lane outputs sampled along 2N-1 anti-diagonals into an NxN matrix and streams it out row by row.
// Latency: OFFSET+2N-1 in_en-qualified edges from start acceptance to the first out_valid, then one row per handshake.
// Backpressure: in_en low freezes counter and capture; out_ready low holds out_row/out_row_idx stable while draining.
module systolic_result_collector #(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int OFFSET = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic                                           in_en,
  input  logic [N*DW-1:0]                                in_data,
  output logic                                           busy,
  output logic                                           err_start,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [N*DW-1:0]                                out_row,
  output logic [(($clog2(N) > 1) ? $clog2(N) : 1)-1:0]   out_row_idx,
  output logic                                           out_last
);

  localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(OFFSET + 2*N);

  localparam logic [CW-1:0] CNT_FIRST = CW'(OFFSET);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OFFSET + 2*N - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;
  logic            cap_en;
  logic [DW-1:0]   mat_q [N][N];

  // Element M[r][c] lies on diagonal r+c; the lane feeding it is r minus the
  // first row index that diagonal touches, so every element has a fixed source.
  function automatic int lane_of(input int r, input int c);
    int base;
    base = (r + c > N - 1) ? (r + c - N + 1) : 0;
    return r - base;
  endfunction

  // State, counter, drain index and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start acceptance, in_en-qualified counting, row draining.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cap_en  = 1'b0;
    err_d   = start && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (OFFSET == 0) ? CAPTURE : ALIGN;
        end
      end
      ALIGN: begin
        if (in_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_FIRST) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (in_en) begin
          cap_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
            idx_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Matrix capture: each element loads from its fixed lane when the counter hits its diagonal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else if (cap_en) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (cnt_q == CW'(OFFSET + r + c)) begin
            mat_q[r][c] <= in_data[lane_of(r, c)*DW +: DW];
          end
        end
      end
    end
  end

  // Row mux: out_row always shows the row selected by the drain index.
  always_comb begin
    out_row = '0;
    for (int c = 0; c < N; c++) begin
      out_row[c*DW +: DW] = mat_q[idx_q][c];
    end
  end

  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DRAIN);
  assign out_last    = out_valid && (idx_q == IDX_LAST);
  assign out_row_idx = idx_q;
  assign err_start   = err_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: drives three collector instances (N=4/OFFSET=8, N=2/OFFSET=0, N=8/DW=16/OFFSET=3)
// and compares every drained row against matrices rebuilt from the recorded diagonal samples.
// Inputs change on the falling edge; outputs are sampled on the falling edge before new inputs are applied.
`timescale 1ns/1ps
module tb_systolic_result_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_en, out_ready;
  logic         start_a, start_b, start_c;
  logic [127:0] in_data;

  logic a_busy, a_err, a_vld, a_last;  logic [127:0] a_row;  logic [1:0] a_idx;
  logic b_busy, b_err, b_vld, b_last;  logic [63:0]  b_row;  logic [0:0] b_idx;
  logic c_busy, c_err, c_vld, c_last;  logic [127:0] c_row;  logic [2:0] c_idx;

  systolic_result_collector #(.N(4), .DW(32), .OFFSET(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_en(in_en), .in_data(in_data),
    .busy(a_busy), .err_start(a_err), .out_valid(a_vld), .out_ready(out_ready),
    .out_row(a_row), .out_row_idx(a_idx), .out_last(a_last));

  systolic_result_collector #(.N(2), .DW(32), .OFFSET(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_en(in_en), .in_data(in_data[63:0]),
    .busy(b_busy), .err_start(b_err), .out_valid(b_vld), .out_ready(out_ready),
    .out_row(b_row), .out_row_idx(b_idx), .out_last(b_last));

  systolic_result_collector #(.N(8), .DW(16), .OFFSET(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .in_en(in_en), .in_data(in_data),
    .busy(c_busy), .err_start(c_err), .out_valid(c_vld), .out_ready(out_ready),
    .out_row(c_row), .out_row_idx(c_idx), .out_last(c_last));

  int total = 0;
  int bad   = 0;

  bit cfg_pat;
  int cfg_stall_q, cfg_stall_len;
  bit cfg_bp;
  int cfg_st_e1, cfg_st_e2;
  bit cfg_st_last;
  int cfg_rst_at;

  logic [127:0] diag_m   [0:14];
  logic [127:0] exp_rows [0:7];
  logic [127:0] obs_row  [0:7];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic g_busy(input int sel);
    case (sel) 0: return a_busy; 1: return b_busy; default: return c_busy; endcase
  endfunction
  function automatic logic g_vld(input int sel);
    case (sel) 0: return a_vld; 1: return b_vld; default: return c_vld; endcase
  endfunction
  function automatic logic g_last(input int sel);
    case (sel) 0: return a_last; 1: return b_last; default: return c_last; endcase
  endfunction
  function automatic logic g_err(input int sel);
    case (sel) 0: return a_err; 1: return b_err; default: return c_err; endcase
  endfunction
  function automatic int g_idx(input int sel);
    case (sel) 0: return int'(a_idx); 1: return int'(b_idx); default: return int'(c_idx); endcase
  endfunction
  function automatic logic [127:0] g_row(input int sel);
    case (sel) 0: return a_row; 1: return {64'h0, b_row}; default: return c_row; endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    start_a = (sel == 0) ? v : 1'b0;
    start_b = (sel == 1) ? v : 1'b0;
    start_c = (sel == 2) ? v : 1'b0;
  endtask

  task automatic chk_zero(input int sel);
    chk("rst_busy", g_busy(sel), 0);
    chk("rst_err",  g_err(sel),  0);
    chk("rst_vld",  g_vld(sel),  0);
    chk("rst_last", g_last(sel), 0);
    chk("rst_idx",  g_idx(sel),  0);
    chk("rst_row",  g_row(sel),  0);
  endtask

  // One full matrix: start, feed diagonals (with optional stalls/start pulses/reset), then drain.
  task automatic run(input int sel);
    int n, dw, off, q, edges, stalls, e_idx, bp_i;
    logic [127:0] mask, elem;
    bit st_now, err_exp, rdy;
    bit [6:0] bp_pat;
    bp_pat = 7'b1110100;
    n   = (sel == 0) ? 4 : (sel == 1) ? 2 : 8;
    dw  = (sel == 2) ? 16 : 32;
    off = (sel == 0) ? 8 : (sel == 1) ? 0 : 3;
    mask = (128'd1 << dw) - 128'd1;

    @(negedge clk);
    chk("idle_busy", g_busy(sel), 0);
    set_start(sel, 1'b1);
    in_en   = 1'b1;
    in_data = rnd128();
    @(negedge clk);
    set_start(sel, 1'b0);

    err_exp = 1'b0; q = 0; edges = 0; stalls = 0;
    while (q < off + 2*n - 1 && edges < 400) begin
      chk("cap_vld",  g_vld(sel),  0);
      chk("cap_busy", g_busy(sel), 1);
      chk("cap_err",  g_err(sel),  err_exp);
      if (cfg_stall_len > 0 && q == off + cfg_stall_q && stalls < cfg_stall_len) begin
        in_en = 1'b0;
        stalls++;
      end else begin
        in_en = 1'b1;
      end
      in_data = rnd128();
      if (in_en && q >= off) begin
        if (cfg_pat) begin
          for (int j = 0; j < n; j++) in_data[j*32 +: 32] = ((q - off) << 16) | j;
        end
        diag_m[q - off] = in_data;
      end
      st_now = (edges == cfg_st_e1) || (edges == cfg_st_e2);
      set_start(sel, st_now);
      if (edges == cfg_rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero(sel);
        @(negedge clk);
        rst_n = 1'b1;
        set_start(sel, 1'b0);
        in_en = 1'b1;
        return;
      end
      @(negedge clk);
      set_start(sel, 1'b0);
      err_exp = st_now;
      edges++;
      if (in_en) q++;
    end
    chk("cap_bound", edges < 400, 1);

    for (int r = 0; r < 8; r++) exp_rows[r] = '0;
    for (int k = 0; k <= 2*n - 2; k++) begin
      for (int j = 0; j < n; j++) begin
        int r, c;
        r = (((k - n + 1) > 0) ? (k - n + 1) : 0) + j;
        c = k - r;
        if (r <= ((k < n - 1) ? k : n - 1)) begin
          elem = (diag_m[k] >> (j*dw)) & mask;
          exp_rows[r] = exp_rows[r] | (elem << (c*dw));
        end
      end
    end

    e_idx = 0; bp_i = 0;
    while (e_idx < n && bp_i < 100) begin
      chk("drn_vld",  g_vld(sel),  1);
      chk("drn_busy", g_busy(sel), 1);
      chk("drn_idx",  g_idx(sel),  e_idx);
      chk("drn_last", g_last(sel), e_idx == n - 1);
      chk("drn_row",  g_row(sel),  exp_rows[e_idx]);
      chk("drn_err",  g_err(sel),  err_exp);
      obs_row[e_idx] = g_row(sel);
      rdy = cfg_bp ? ((bp_i < 7) ? bp_pat[bp_i] : 1'b1) : 1'b1;
      out_ready = rdy;
      in_en     = 1'($urandom_range(0, 1));
      in_data   = rnd128();
      st_now = cfg_st_last && rdy && (e_idx == n - 1);
      set_start(sel, st_now);
      @(negedge clk);
      set_start(sel, 1'b0);
      err_exp = st_now;
      bp_i++;
      if (rdy) e_idx++;
    end
    chk("drn_bound", e_idx, n);
    if (cfg_bp) chk("bp_cycles", bp_i, 7);
    chk("end_vld",  g_vld(sel),  0);
    chk("end_last", g_last(sel), 0);
    chk("end_busy", g_busy(sel), 0);
    chk("end_err",  g_err(sel),  err_exp);
    @(negedge clk);
    chk("end_err2", g_err(sel),  0);
    chk("end_busy2", g_busy(sel), 0);
    in_en = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    in_en = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_pat = 1'b0; cfg_stall_q = 0; cfg_stall_len = 0; cfg_bp = 1'b0;
    cfg_st_e1 = -1; cfg_st_e2 = -1; cfg_st_last = 1'b0; cfg_rst_at = -1;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) chk_zero(s);
    rst_n = 1'b1;
    in_en = 1'b1;
    out_ready = 1'b1;

    cfg_pat = 1'b1;
    run(0);
    chk("smoke_row0", obs_row[0], 128'h00030000_00020000_00010000_00000000);
    chk("smoke_row1", obs_row[1], 128'h00040000_00030001_00020001_00010001);
    chk("smoke_row2", obs_row[2], 128'h00050000_00040001_00030002_00020002);
    chk("smoke_row3", obs_row[3], 128'h00060000_00050001_00040002_00030003);

    cfg_stall_q = 3; cfg_stall_len = 3;
    run(0);
    chk("stall_row3", obs_row[3], 128'h00060000_00050001_00040002_00030003);
    cfg_stall_len = 0; cfg_pat = 1'b0;

    cfg_bp = 1'b1;
    run(0);
    cfg_bp = 1'b0;

    cfg_st_e1 = 2; cfg_st_e2 = 11; cfg_st_last = 1'b1;
    run(0);
    cfg_st_e1 = -1; cfg_st_e2 = -1; cfg_st_last = 1'b0;

    cfg_rst_at = 10;
    run(0);
    cfg_rst_at = -1;
    run(0);

    run(1);
    chk("n2_m11", (obs_row[1] >> 32) & 128'hffff_ffff, diag_m[2] & 128'hffff_ffff);

    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
